// File: rtl/dht11_read_scheduler_pkg.sv
// Shared definitions for the DHT11 read scheduler: FSM state encoding,
// requester bit positions, timer width and a saturating increment helper.
package dht11_read_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StLaunch = 3'd2,
    StBusy   = 3'd3,
    StCheck  = 3'd4,
    StFail   = 3'd5,
    StRetry  = 3'd6,
    StFinish = 3'd7
  } state_e;

  // Requester bit positions in the pending / served masks.
  localparam int unsigned ReqBtn  = 0;
  localparam int unsigned ReqUart = 1;
  localparam int unsigned ReqAuto = 2;

  // Width of the millisecond down-counters; periods must fit below 2^16 ms.
  localparam int unsigned CntW = 16;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dht11_ms_timer.sv
// Millisecond down-counter: a prescaler turns 1 us ticks into ms ticks and a
// loadable counter counts down to 0, where it sticks and flags expired.
// Loading also restarts the prescaler so a load always measures a full period.
module dht11_ms_timer
  import dht11_read_scheduler_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = 1000,
  parameter int unsigned PERIOD_MS    = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1us,
  input  logic load,
  output logic expired
);

  localparam int unsigned PreW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [PreW-1:0] pre_q;
  logic [CntW-1:0] cnt_q;

  // Prescaler and down-counter; reset value is the full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= CntW'(PERIOD_MS);
    end else if (load) begin
      pre_q <= '0;
      cnt_q <= CntW'(PERIOD_MS);
    end else if (tick_1us) begin
      if (pre_q == PreW'(TICKS_PER_MS - 1)) begin
        pre_q <= '0;
        if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
      end else begin
        pre_q <= pre_q + PreW'(1);
      end
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: merges button, UART and auto-poll requests into
// sensor transactions, enforces the inter-read gap, retries failed reads,
// resets a hung control unit and keeps the last good humidity/temperature.
// Optional: define DHT11_SCHED_STATS_EN for success / failed-attempt counters.
module dht11_read_scheduler
  import dht11_read_scheduler_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS   = 1000,
  parameter int unsigned MIN_GAP_MS     = 2000,
  parameter int unsigned AUTO_PERIOD_MS = 5000,
  parameter int unsigned TIMEOUT_MS     = 40,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick_1us,
  input  logic        i_btn_req,
  input  logic        i_uart_req,
  input  logic        i_auto_en,
  input  logic [3:0]  i_sensor_state,
  input  logic        i_sensor_valid,
  input  logic [7:0]  i_humidity,
  input  logic [7:0]  i_temperature,
  output logic        o_start,
  output logic        o_sensor_rst,
  output logic [7:0]  o_humidity,
  output logic [7:0]  o_temperature,
  output logic        o_data_valid,
  output logic        o_err,
  output logic        o_done,
  output logic [2:0]  o_served,
  output logic        o_busy,
  output logic [15:0] o_ok_cnt,
  output logic [15:0] o_fail_cnt
);

  state_e     state_q;
  logic [2:0] pending_q, active_q, req_set;
  logic [7:0] retry_q;
  logic       retry_left, auto_fire;
  logic       gap_expired, auto_expired, to_expired;
  logic       gap_load, auto_load, to_load;

  assign retry_left = (retry_q < 8'(MAX_RETRY));
  assign auto_fire  = i_auto_en & auto_expired;
  assign gap_load   = (state_q == StFinish) || ((state_q == StFail) && retry_left);
  assign to_load    = (state_q == StStart);
  // Holding the load while disabled keeps the auto timer at its reload value.
  assign auto_load  = ~i_auto_en | auto_expired;

  // New request bits from all three sources this cycle.
  always_comb begin
    req_set          = '0;
    req_set[ReqBtn]  = i_btn_req;
    req_set[ReqUart] = i_uart_req;
    req_set[ReqAuto] = auto_fire;
  end

  dht11_ms_timer #(.TICKS_PER_MS(TICKS_PER_MS), .PERIOD_MS(MIN_GAP_MS)) u_gap_timer (
    .clk(clk), .rst(rst), .tick_1us(i_tick_1us), .load(gap_load), .expired(gap_expired)
  );

  dht11_ms_timer #(.TICKS_PER_MS(TICKS_PER_MS), .PERIOD_MS(AUTO_PERIOD_MS)) u_auto_timer (
    .clk(clk), .rst(rst), .tick_1us(i_tick_1us), .load(auto_load), .expired(auto_expired)
  );

  dht11_ms_timer #(.TICKS_PER_MS(TICKS_PER_MS), .PERIOD_MS(TIMEOUT_MS)) u_timeout_timer (
    .clk(clk), .rst(rst), .tick_1us(i_tick_1us), .load(to_load), .expired(to_expired)
  );

  // Transaction FSM with registered outputs and the pending request mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      active_q      <= '0;
      retry_q       <= '0;
      o_start       <= 1'b0;
      o_sensor_rst  <= 1'b0;
      o_humidity    <= '0;
      o_temperature <= '0;
      o_data_valid  <= 1'b0;
      o_err         <= 1'b0;
      o_done        <= 1'b0;
      o_served      <= '0;
      o_busy        <= 1'b0;
    end else begin
      o_start      <= 1'b0;
      o_sensor_rst <= 1'b0;
      o_done       <= 1'b0;
      o_served     <= '0;
      pending_q    <= pending_q | req_set;
      unique case (state_q)
        StIdle: begin
          if ((pending_q != '0) && gap_expired) begin
            // Snapshot takes every pending bit; only this cycle's arrivals stay.
            active_q  <= pending_q;
            pending_q <= req_set;
            o_start   <= 1'b1;
            o_busy    <= 1'b1;
            state_q   <= StStart;
          end
        end
        StStart: state_q <= StLaunch;
        StLaunch, StBusy: begin
          if (to_expired) begin
            o_sensor_rst <= 1'b1;
            state_q      <= StFail;
          end else if ((state_q == StLaunch) && (i_sensor_state != 4'd0)) begin
            state_q <= StBusy;
          end else if ((state_q == StBusy) && (i_sensor_state == 4'd0)) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (i_sensor_valid) begin
            o_humidity    <= i_humidity;
            o_temperature <= i_temperature;
            o_data_valid  <= 1'b1;
            o_err         <= 1'b0;
            o_done        <= 1'b1;
            o_served      <= active_q;
            state_q       <= StFinish;
          end else begin
            state_q <= StFail;
          end
        end
        StFail: begin
          if (retry_left) begin
            retry_q <= retry_q + 8'd1;
            state_q <= StRetry;
          end else begin
            o_err    <= 1'b1;
            o_done   <= 1'b1;
            o_served <= active_q;
            state_q  <= StFinish;
          end
        end
        StRetry: begin
          if (gap_expired) begin
            o_start <= 1'b1;
            state_q <= StStart;
          end
        end
        StFinish: begin
          retry_q <= '0;
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DHT11_SCHED_STATS_EN
  logic        ok_inc, fail_inc;
  logic [15:0] ok_cnt_q, fail_cnt_q;

  assign ok_inc   = (state_q == StCheck) && i_sensor_valid;
  assign fail_inc = ((state_q == StCheck) && !i_sensor_valid) ||
                    (((state_q == StLaunch) || (state_q == StBusy)) && to_expired);

  // Saturating counters of good transactions and of failed attempts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt_q   <= '0;
      fail_cnt_q <= '0;
    end else begin
      if (ok_inc)   ok_cnt_q   <= sat_inc(ok_cnt_q);
      if (fail_inc) fail_cnt_q <= sat_inc(fail_cnt_q);
    end
  end

  assign o_ok_cnt   = ok_cnt_q;
  assign o_fail_cnt = fail_cnt_q;
`else
  assign o_ok_cnt   = '0;
  assign o_fail_cnt = '0;
`endif

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Self-checking bench for dht11_read_scheduler: directed and random
// transaction table checked against a transaction-level model, plus
// hand-written sequences for holdoff, merging, auto-poll and reset.
module tb_dht11_read_scheduler;

  localparam int TPM = 10, GAP = 3, AUTO = 20, TO = 5, MR = 2, TDIV = 4;
  localparam int GAP_CYC = GAP * TPM * TDIV;
  localparam int TO_CYC = TO * TPM * TDIV;
  localparam int KOK = 0, KBAD = 1, KSTUCK = 2;
  localparam int ND = 5, NR = 10, NV = ND + NR;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] h;
    logic [7:0] t;
  } att_t;

  typedef struct {
    logic [2:0]       req;
    att_t [2:0]       att;
    int               exp_starts;
    int               exp_rsts;
    logic [2:0]       exp_served;
    logic             exp_err;
    logic [7:0]       exp_h;
    logic [7:0]       exp_t;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic btn = 1'b0, uart = 1'b0, auto_en = 1'b0;
  logic [3:0] sens_state = 4'd0;
  logic sens_valid = 1'b0;
  logic [7:0] sens_h = 8'd0, sens_t = 8'd0;
  logic o_start, o_sensor_rst, o_data_valid, o_err, o_done, o_busy;
  logic [7:0] o_humidity, o_temperature;
  logic [2:0] o_served;
  logic [15:0] o_ok_cnt, o_fail_cnt;

  dht11_read_scheduler #(
    .TICKS_PER_MS(TPM), .MIN_GAP_MS(GAP), .AUTO_PERIOD_MS(AUTO),
    .TIMEOUT_MS(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst), .i_tick_1us(tick), .i_btn_req(btn), .i_uart_req(uart),
    .i_auto_en(auto_en), .i_sensor_state(sens_state), .i_sensor_valid(sens_valid),
    .i_humidity(sens_h), .i_temperature(sens_t), .o_start(o_start),
    .o_sensor_rst(o_sensor_rst), .o_humidity(o_humidity), .o_temperature(o_temperature),
    .o_data_valid(o_data_valid), .o_err(o_err), .o_done(o_done), .o_served(o_served),
    .o_busy(o_busy), .o_ok_cnt(o_ok_cnt), .o_fail_cnt(o_fail_cnt)
  );

  always #5 clk = ~clk;

  // 1 us tick every TDIV clocks.
  initial begin
    forever begin
      repeat (TDIV - 1) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  // Sensor control-unit model: plays one queued attempt per o_start.
  att_t att_q[$];
  initial begin
    att_t a;
    forever begin
      @(posedge clk);
      #1;
      if (o_start && !rst) begin
        a = (att_q.size() > 0) ? att_q.pop_front() : {2'd0, 8'd40, 8'd20};
        sens_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 sens_state = 4'd2;
        if (int'(a.kind) == KSTUCK) begin
          for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (o_sensor_rst || rst) break;
          end
          sens_state = 4'd0;
        end else begin
          repeat (20) @(posedge clk);
          #1;
          sens_valid = (int'(a.kind) == KOK);
          sens_h = a.h;
          sens_t = a.t;
          sens_state = 4'd0;
        end
      end
    end
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_start = 0, n_rst = 0, n_done = 0, last_done_t = 0;
  int start_t[$], rst_t[$];
  logic [7:0] mdl_h, mdl_t;

  // Advance one clock and record output events.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (o_start) begin n_start++; start_t.push_back(cyc); end
    if (o_sensor_rst) begin n_rst++; rst_t.push_back(cyc); end
    if (o_done) begin n_done++; last_done_t = cyc; end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic pulse(input logic [2:0] r);
    btn = r[0];
    uart = r[1];
    step();
    btn = 1'b0;
    uart = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, i;
    d0 = n_done;
    i = 0;
    while (n_done == d0 && i < budget) begin step(); i++; end
    if (n_done == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no o_done within %0d cycles, got 0 expected 1", name, budget);
    end
  endtask

  task automatic wait_start(input string name, input int budget);
    int s0, i;
    s0 = n_start;
    i = 0;
    while (n_start == s0 && i < budget) begin step(); i++; end
    check(name, n_start - s0, 1);
  endtask

  function automatic att_t mk_att(input int k, input int h, input int t);
    att_t a;
    a.kind = 2'(k);
    a.h = 8'(h);
    a.t = 8'(t);
    return a;
  endfunction

  function automatic vec_t mk_vec(input logic [2:0] req, input att_t a0, input att_t a1,
                                  input att_t a2, input int starts, input int rsts,
                                  input logic err, input int h, input int t);
    vec_t v;
    v.req = req;
    v.att[0] = a0;
    v.att[1] = a1;
    v.att[2] = a2;
    v.exp_starts = starts;
    v.exp_rsts = rsts;
    v.exp_served = req;
    v.exp_err = err;
    v.exp_h = 8'(h);
    v.exp_t = 8'(t);
    return v;
  endfunction

  // Transaction model: attempts run until the first good read or MAX_RETRY+1
  // tries; stuck attempts each cost a sensor reset; data only moves on success.
  function automatic vec_t model_row(input vec_t v);
    vec_t r;
    bit ok;
    r = v;
    ok = 0;
    r.exp_starts = 0;
    r.exp_rsts = 0;
    for (int k = 0; k <= MR; k++) begin
      if (!ok) begin
        r.exp_starts++;
        if (int'(v.att[k].kind) == KOK) begin
          ok = 1;
          mdl_h = v.att[k].h;
          mdl_t = v.att[k].t;
        end else if (int'(v.att[k].kind) == KSTUCK) begin
          r.exp_rsts++;
        end
      end
    end
    r.exp_served = v.req;
    r.exp_err = !ok;
    r.exp_h = mdl_h;
    r.exp_t = mdl_t;
    return r;
  endfunction

  function automatic int rand_kind();
    int r;
    r = int'($urandom_range(0, 9));
    return (r < 5) ? KOK : (r < 8) ? KBAD : KSTUCK;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[NV];
    vec_t v;
    int rel, ok_total, fail_total, d0;
    logic [2:0] rq;

    // Directed rows, expectations written by hand.
    vecs[0] = mk_vec(3'b011, mk_att(KOK, 60, 25), mk_att(KOK, 1, 1), mk_att(KOK, 1, 1),
                     1, 0, 1'b0, 60, 25);
    vecs[1] = mk_vec(3'b010, mk_att(KBAD, 8'hEE, 8'hEE), mk_att(KBAD, 8'hDD, 8'hDD),
                     mk_att(KBAD, 8'hCC, 8'hCC), 3, 0, 1'b1, 60, 25);
    vecs[2] = mk_vec(3'b001, mk_att(KSTUCK, 0, 0), mk_att(KOK, 61, 26), mk_att(KOK, 1, 1),
                     2, 1, 1'b0, 61, 26);
    vecs[3] = mk_vec(3'b001, mk_att(KSTUCK, 0, 0), mk_att(KSTUCK, 0, 0),
                     mk_att(KSTUCK, 0, 0), 3, 3, 1'b1, 61, 26);
    vecs[4] = mk_vec(3'b010, mk_att(KBAD, 9, 9), mk_att(KBAD, 8, 8), mk_att(KOK, 70, 30),
                     3, 0, 1'b0, 70, 30);
    // Random rows, expectations from the model.
    mdl_h = vecs[ND-1].exp_h;
    mdl_t = vecs[ND-1].exp_t;
    for (int i = ND; i < NV; i++) begin
      rq = 3'($urandom_range(1, 3));
      v = mk_vec(rq, mk_att(rand_kind(), int'($urandom_range(0, 255)), int'($urandom_range(0, 255))),
                 mk_att(rand_kind(), int'($urandom_range(0, 255)), int'($urandom_range(0, 255))),
                 mk_att(rand_kind(), int'($urandom_range(0, 255)), int'($urandom_range(0, 255))),
                 0, 0, 1'b0, 0, 0);
      vecs[i] = model_row(v);
    end

    // Reset state.
    repeat (5) step();
    check("reset outputs", int'({o_start, o_sensor_rst, o_humidity, o_temperature,
                                 o_data_valid, o_err, o_done, o_served, o_busy}), 0);
    check("reset stats", int'({o_ok_cnt, o_fail_cnt}), 0);
    rst = 1'b0;
    rel = cyc;

    // Button 1 ms after reset waits for the power-on holdoff.
    repeat (TPM * TDIV) step();
    att_q.push_back(mk_att(KOK, 55, 23));
    pulse(3'b001);
    wait_done("holdoff done", 1000);
    check("holdoff start count", n_start, 1);
    if (n_start > 0) check_range("holdoff start time", start_t[0] - rel, GAP_CYC - 4, GAP_CYC + 10);
    check("first served", int'(o_served), 1);
    check("first humidity", int'(o_humidity), 55);
    check("first temperature", int'(o_temperature), 23);
    check("first data_valid", int'(o_data_valid), 1);
    check("first err", int'(o_err), 0);
    ok_total = 1;
    fail_total = 0;

    // Table-driven transactions.
    for (int i = 0; i < NV; i++) begin
      int s0, r0, sidx, ridx, prev_done, mn, lo, hi, lat, sb;
      s0 = n_start;
      r0 = n_rst;
      sidx = start_t.size();
      ridx = rst_t.size();
      prev_done = last_done_t;
      for (int k = 0; k <= MR; k++) att_q.push_back(vecs[i].att[k]);
      pulse(vecs[i].req);
      wait_done($sformatf("row%0d done", i), 4000);
      check($sformatf("row%0d starts", i), n_start - s0, vecs[i].exp_starts);
      check($sformatf("row%0d sensor_rst", i), n_rst - r0, vecs[i].exp_rsts);
      check($sformatf("row%0d served", i), int'(o_served), int'(vecs[i].exp_served));
      check($sformatf("row%0d err", i), int'(o_err), int'(vecs[i].exp_err));
      check($sformatf("row%0d humidity", i), int'(o_humidity), int'(vecs[i].exp_h));
      check($sformatf("row%0d temperature", i), int'(o_temperature), int'(vecs[i].exp_t));
      check($sformatf("row%0d data_valid", i), int'(o_data_valid), 1);
      if (start_t.size() > sidx) begin
        mn = start_t[sidx] - prev_done;
        for (int j = sidx + 1; j < start_t.size(); j++)
          if (start_t[j] - start_t[j-1] < mn) mn = start_t[j] - start_t[j-1];
        check_range($sformatf("row%0d start spacing", i), mn, GAP_CYC - 4, 1 << 30);
      end
      if (rst_t.size() > ridx) begin
        lo = 1 << 30;
        hi = 0;
        for (int j = ridx; j < rst_t.size(); j++) begin
          sb = 0;
          foreach (start_t[m]) if (start_t[m] <= rst_t[j]) sb = start_t[m];
          lat = rst_t[j] - sb;
          if (lat < lo) lo = lat;
          if (lat > hi) hi = lat;
        end
        check_range($sformatf("row%0d rst latency min", i), lo, TO_CYC - 10, TO_CYC + 15);
        check_range($sformatf("row%0d rst latency max", i), hi, TO_CYC - 10, TO_CYC + 15);
      end
      att_q.delete();
      step();
      check($sformatf("row%0d busy after done", i), int'(o_busy), 0);
      ok_total += vecs[i].exp_err ? 0 : 1;
      fail_total += vecs[i].exp_starts - (vecs[i].exp_err ? 0 : 1);
    end

    // UART during BUSY is served by the next transaction.
    att_q.push_back(mk_att(KOK, 81, 41));
    att_q.push_back(mk_att(KOK, 82, 42));
    pulse(3'b001);
    wait_start("busy seq first start", 600);
    repeat (10) step();
    pulse(3'b010);
    wait_done("busy seq done1", 1000);
    check("busy seq served1", int'(o_served), 1);
    check("busy seq humidity1", int'(o_humidity), 81);
    d0 = last_done_t;
    wait_done("busy seq done2", 1000);
    check("busy seq served2", int'(o_served), 2);
    check("busy seq humidity2", int'(o_humidity), 82);
    check_range("busy seq gap", start_t[$] - d0, GAP_CYC - 4, GAP_CYC + 10);
    ok_total += 2;

    // Auto-poll alone.
    att_q.delete();
    att_q.push_back(mk_att(KOK, 90, 50));
    att_q.push_back(mk_att(KOK, 91, 51));
    auto_en = 1'b1;
    wait_done("auto done1", 1500);
    check("auto served1", int'(o_served), 4);
    check("auto humidity1", int'(o_humidity), 90);
    d0 = start_t[$];
    wait_done("auto done2", 1500);
    auto_en = 1'b0;
    check("auto served2", int'(o_served), 4);
    check("auto temperature2", int'(o_temperature), 51);
    check_range("auto period", start_t[$] - d0, AUTO * TPM * TDIV - 20, AUTO * TPM * TDIV + 100);
    ok_total += 2;

`ifdef DHT11_SCHED_STATS_EN
    check("ok count", int'(o_ok_cnt), ok_total);
    check("fail count", int'(o_fail_cnt), fail_total);
`else
    check("ok count tied", int'(o_ok_cnt), 0);
    check("fail count tied", int'(o_fail_cnt), 0);
`endif

    // Reset in the middle of a hung read.
    att_q.delete();
    att_q.push_back(mk_att(KSTUCK, 0, 0));
    repeat (GAP_CYC) step();
    pulse(3'b001);
    wait_start("rst mid start", 600);
    repeat (20) step();
    rst = 1'b1;
    step();
    step();
    check("rst mid outputs", int'({o_start, o_sensor_rst, o_humidity, o_temperature,
                                   o_data_valid, o_err, o_done, o_served, o_busy}), 0);
    d0 = n_done;
    rst = 1'b0;
    rel = cyc;
    att_q.delete();
    att_q.push_back(mk_att(KOK, 99, 9));
    repeat (30) step();
    check("rst mid no done", n_done - d0, 0);
    pulse(3'b001);
    wait_done("rst mid done", 1000);
    check("rst mid done count", n_done - d0, 1);
    check_range("rst mid holdoff", start_t[$] - rel, GAP_CYC - 4, GAP_CYC + 10);
    check("rst mid humidity", int'(o_humidity), 99);
    check("rst mid served", int'(o_served), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
